// File: rtl/seven_segment_mux.sv
//----------------------------------------------------------------------------
// seven_segment_mux: two-digit multiplexed 7-segment driver with frame-aligned commit
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module seven_segment_mux #(
  parameter int REFRESH_CYCLES     = 100,
  parameter bit BLANK_LEADING_ZERO = 1'b1,
  parameter bit SEG_ACTIVE_LOW     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ten_count,
  input  logic [3:0] unit_count,
  output logic [6:0] segments,
  output logic       digit
);

  localparam int            CW        = $clog2(REFRESH_CYCLES);
  localparam logic [CW-1:0] LAST      = CW'(REFRESH_CYCLES - 1);
  localparam logic [6:0]    BLANK_PAT = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [CW-1:0] count;
  logic        pending;
  logic [3:0]  pend_ten;
  logic [3:0]  pend_unit;
  logic [3:0]  shown_ten;
  logic [3:0]  shown_unit;
  logic        wrap;
  logic        commit;
  logic        digit_next;
  logic [3:0]  ten_next;
  logic [3:0]  unit_next;
  logic [3:0]  sel_val;
  logic [6:0]  glyph;
  logic [6:0]  raw_seg;
  logic [6:0]  seg_next;

  // A frame is units then tens, so the boundary is the wrap that ends the tens period.
  assign wrap       = (count == LAST);
  assign commit     = wrap & digit;
  assign digit_next = wrap ? ~digit : digit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BLANK;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ten_next   = shown_ten;
    unit_next  = shown_unit;
    if (commit && load) begin
      ten_next   = ten_count;
      unit_next  = unit_count;
      state_next = ST_SHOW;
    end else if (commit && pending) begin
      ten_next   = pend_ten;
      unit_next  = pend_unit;
      state_next = ST_SHOW;
    end

    // Decode from next-cycle values so segments and digit change on the same edge.
    sel_val = digit_next ? ten_next : unit_next;
    case (sel_val)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h79;
    endcase

    raw_seg = glyph;
    if (state_next == ST_BLANK) begin
      raw_seg = 7'h00;
    end else if (digit_next && BLANK_LEADING_ZERO && (ten_next == 4'd0)) begin
      raw_seg = 7'h00;
    end
    seg_next = SEG_ACTIVE_LOW ? ~raw_seg : raw_seg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      digit      <= 1'b0;
      pending    <= 1'b0;
      pend_ten   <= 4'd0;
      pend_unit  <= 4'd0;
      shown_ten  <= 4'd0;
      shown_unit <= 4'd0;
      segments   <= BLANK_PAT;
    end else begin
      count      <= wrap ? '0 : count + 1'b1;
      digit      <= digit_next;
      shown_ten  <= ten_next;
      shown_unit <= unit_next;
      segments   <= seg_next;
      if (commit) begin
        pending <= 1'b0;
      end else if (load) begin
        pending   <= 1'b1;
        pend_ten  <= ten_count;
        pend_unit <= unit_count;
      end
    end
  end

endmodule

`default_nettype wire
